// File: rtl/wb_arbiter.sv
// wb_arbiter: three-source write-back arbiter for a dual write-port register file.
// Each source (0 = matmul, 1 = ALU, 2 = load) has its own FIFO of {addr, data}.
// Each cycle the FIFO heads are visited round-robin from rr_q. The first non-empty
// head wins port C. The next head with a different address wins port D.
// Port outputs are registered, so a write shows up one cycle after its grant.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   src_valid[2:0] / src_ready[2:0] per-source request / accept
//   src_addr  [3*ADDR_W-1:0]        per-source destination register (slice i)
//   src_data  [3*REG_WIDTH-1:0]     per-source write data (slice i)
//   port_{c,d}_we                   register-file write enables
//   port_{c,d}_write_addr           write addresses
//   port_{c,d}_in                   write data
//   pend_mask [NREG-1:0]            registers with a queued or presented write
module wb_arbiter #(
    parameter int unsigned REG_CNT           = 4,
    parameter int unsigned SUPERSCALAR_WIDTH = 4,
    parameter int unsigned REG_WIDTH         = 288,
    parameter int unsigned DEPTH             = 4,
    localparam int unsigned NREG             = REG_CNT * SUPERSCALAR_WIDTH,
    localparam int unsigned ADDR_W           = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             src_valid,
    output logic [2:0]             src_ready,
    input  logic [3*ADDR_W-1:0]    src_addr,
    input  logic [3*REG_WIDTH-1:0] src_data,
    output logic                   port_c_we,
    output logic [ADDR_W-1:0]      port_c_write_addr,
    output logic [REG_WIDTH-1:0]   port_c_in,
    output logic                   port_d_we,
    output logic [ADDR_W-1:0]      port_d_write_addr,
    output logic [REG_WIDTH-1:0]   port_d_in,
    output logic [NREG-1:0]        pend_mask
);

    localparam int unsigned NSRC  = 3;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // FIFO storage is not reset; validity comes only from the pointers and count.
    logic [ADDR_W-1:0]    fifo_addr_q [NSRC][DEPTH];
    logic [REG_WIDTH-1:0] fifo_data_q [NSRC][DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q    [NSRC];
    logic [PTR_W-1:0]     rd_ptr_q    [NSRC];
    logic [CNT_W-1:0]     count_q     [NSRC];

    // Holds src_ready low through reset and until the first edge after release.
    logic                 init_q;
    logic [1:0]           rr_q, rr_d;

    logic [NSRC-1:0]      push, pop, empty;
    logic [ADDR_W-1:0]    head_addr [NSRC];
    logic [REG_WIDTH-1:0] head_data [NSRC];
    logic                 c_gnt, d_gnt;
    logic [1:0]           c_src, d_src;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_ready[i] = init_q && (count_q[i] < CNT_W'(DEPTH));
            push[i]      = src_valid[i] && src_ready[i];
            empty[i]     = (count_q[i] == '0);
            head_addr[i] = fifo_addr_q[i][rd_ptr_q[i]];
            head_data[i] = fifo_data_q[i][rd_ptr_q[i]];
        end
    end

    // Round-robin visit; a head matching port C's address is skipped this cycle.
    always_comb begin
        logic [1:0] s;
        c_gnt = 1'b0;
        c_src = 2'd0;
        d_gnt = 1'b0;
        d_src = 2'd0;
        s     = 2'd0;
        for (int k = 0; k < NSRC; k++) begin
            s = 2'((int'(rr_q) + k) % NSRC);
            if (!empty[s]) begin
                if (!c_gnt) begin
                    c_gnt = 1'b1;
                    c_src = s;
                end else if (!d_gnt && (head_addr[s] != head_addr[c_src])) begin
                    d_gnt = 1'b1;
                    d_src = s;
                end
            end
        end
        pop = '0;
        if (c_gnt) pop[c_src] = 1'b1;
        if (d_gnt) pop[d_src] = 1'b1;
        // D always follows C in visit order, so it is the last grant when present.
        rr_d = rr_q;
        if (d_gnt)      rr_d = inc3(d_src);
        else if (c_gnt) rr_d = inc3(c_src);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                fifo_addr_q[i][wr_ptr_q[i]] <= src_addr[i*ADDR_W +: ADDR_W];
                fifo_data_q[i][wr_ptr_q[i]] <= src_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q            <= 1'b0;
            rr_q              <= 2'd0;
            port_c_we         <= 1'b0;
            port_c_write_addr <= '0;
            port_c_in         <= '0;
            port_d_we         <= 1'b0;
            port_d_write_addr <= '0;
            port_d_in         <= '0;
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            init_q <= 1'b1;
            rr_q   <= rr_d;
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            port_c_we <= c_gnt;
            if (c_gnt) begin
                port_c_write_addr <= head_addr[c_src];
                port_c_in         <= head_data[c_src];
            end
            port_d_we <= d_gnt;
            if (d_gnt) begin
                port_d_write_addr <= head_addr[d_src];
                port_d_in         <= head_data[d_src];
            end
        end
    end

    // Slot j is occupied when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] off;
        pend_mask = '0;
        off       = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                off = PTR_W'(j) - rd_ptr_q[i];
                if (CNT_W'(off) < count_q[i]) pend_mask[fifo_addr_q[i][j]] = 1'b1;
            end
        end
        if (port_c_we) pend_mask[port_c_write_addr] = 1'b1;
        if (port_d_we) pend_mask[port_d_write_addr] = 1'b1;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int NREG  = 16;
    localparam int AW    = 4;
    localparam int RW    = 288;
    localparam int DEPTH = 4;
    localparam int STARVE_LIM = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      src_valid = '0;
    logic [2:0]      src_ready;
    logic [3*AW-1:0] src_addr = '0;
    logic [3*RW-1:0] src_data = '0;
    logic            port_c_we, port_d_we;
    logic [AW-1:0]   port_c_write_addr, port_d_write_addr;
    logic [RW-1:0]   port_c_in, port_d_in;
    logic [NREG-1:0] pend_mask;

    wb_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_addr          (src_addr),
        .src_data          (src_data),
        .port_c_we         (port_c_we),
        .port_c_write_addr (port_c_write_addr),
        .port_c_in         (port_c_in),
        .port_d_we         (port_d_we),
        .port_d_write_addr (port_d_write_addr),
        .port_d_in         (port_d_in),
        .pend_mask         (pend_mask)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: data[9:8] carries the source id, data[7:0] a per-source sequence.
    logic [AW+RW-1:0] sb_q [3][$];
    int               acc_cnt [3];
    int               wr_cnt  [3];
    int               starve  [3];
    logic [7:0]       seq     [3];
    int               addr_mode;
    logic             saw_full0;

    task automatic sb_write(input string tag, input logic [AW-1:0] a, input logic [RW-1:0] d,
                            output int src);
        logic [AW+RW-1:0] e;
        logic ok;
        src = int'(d[9:8]);
        ok  = (src < 3) && (sb_q[src % 3].size() != 0);
        check({tag, "_known_src"}, RW'(ok), RW'(1));
        if (ok) begin
            e = sb_q[src].pop_front();
            wr_cnt[src]++;
            check({tag, "_addr"}, RW'(a), RW'(e[AW+RW-1:RW]));
            check({tag, "_data"}, d, e[RW-1:0]);
        end else begin
            src = 3;
        end
    endtask

    // Called on a falling edge: check outputs, then drive the next cycle's requests.
    task automatic sb_cycle(input logic [2:0] want);
        int sc, sd;
        logic [2:0] wrote;
        logic [AW-1:0] a;
        logic [RW-1:0] d;
        wrote = '0;
        sc = 3;
        sd = 3;
        if (port_c_we) sb_write("c", port_c_write_addr, port_c_in, sc);
        if (port_d_we) sb_write("d", port_d_write_addr, port_d_in, sd);
        if (sc < 3) wrote[sc] = 1'b1;
        if (sd < 3) wrote[sd] = 1'b1;
        if (port_c_we && port_d_we)
            check("cd_addr_distinct", RW'(port_c_write_addr == port_d_write_addr), RW'(0));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ready%0d", i), RW'(src_ready[i]),
                  RW'((acc_cnt[i] - wr_cnt[i]) < DEPTH));
            if (sb_q[i].size() != 0 && !wrote[i]) starve[i]++;
            else starve[i] = 0;
            if (starve[i] > STARVE_LIM) begin
                check($sformatf("starve%0d", i), RW'(starve[i]), RW'(STARVE_LIM));
                starve[i] = 0;
            end
        end
        if (!src_ready[0]) saw_full0 = 1'b1;
        src_valid = want;
        for (int i = 0; i < 3; i++) begin
            a = (addr_mode == 1) ? AW'(3) : AW'($urandom_range(0, NREG - 1));
            d = {9{$urandom()}};
            d[9:8] = 2'(i);
            d[7:0] = seq[i];
            src_addr[i*AW +: AW] = a;
            src_data[i*RW +: RW] = d;
            if (want[i] && src_ready[i]) begin
                sb_q[i].push_back({a, d});
                acc_cnt[i]++;
                seq[i]++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        saw_full0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb_q[i].delete();
            acc_cnt[i] = 0;
            wr_cnt[i]  = 0;
            starve[i]  = 0;
            seq[i]     = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", RW'(src_ready), RW'(0));
        check("rst_c_we", RW'(port_c_we), RW'(0));
        check("rst_d_we", RW'(port_d_we), RW'(0));
        check("rst_c_addr", RW'(port_c_write_addr), RW'(0));
        check("rst_d_data", port_d_in, RW'(0));
        check("rst_pend", RW'(pend_mask), RW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", RW'(src_ready), RW'(3'b111));
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (c < 40 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0) begin
            @(negedge clk);
            sb_cycle(3'b000);
            c++;
        end
        check({tag, "_drained"}, RW'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size()), RW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        int c;
        addr_mode = 0;

        // Single write from source 1.
        do_reset();
        src_valid = 3'b010;
        src_addr[AW +: AW] = AW'(5);
        src_data[RW +: RW] = RW'(32'hA);
        @(negedge clk);
        src_valid = '0;
        check("t1_we_early", RW'(port_c_we), RW'(0));
        check("t1_pend_q", RW'(pend_mask), RW'(16'h0020));
        @(negedge clk);
        check("t1_c_we", RW'(port_c_we), RW'(1));
        check("t1_c_addr", RW'(port_c_write_addr), RW'(5));
        check("t1_c_data", port_c_in, RW'(32'hA));
        check("t1_d_we", RW'(port_d_we), RW'(0));
        check("t1_pend_out", RW'(pend_mask), RW'(16'h0020));
        @(negedge clk);
        check("t1_c_we_off", RW'(port_c_we), RW'(0));
        check("t1_pend_clr", RW'(pend_mask), RW'(0));
        check("t1_c_addr_hold", RW'(port_c_write_addr), RW'(5));

        // Three sources at once, distinct addresses.
        do_reset();
        src_valid = 3'b111;
        src_addr  = {AW'(3), AW'(2), AW'(1)};
        src_data  = {RW'(32'h3), RW'(32'h2), RW'(32'h1)};
        @(negedge clk);
        src_valid = '0;
        check("t2_pend", RW'(pend_mask), RW'(16'h000E));
        @(negedge clk);
        check("t2_c1_we", RW'(port_c_we), RW'(1));
        check("t2_c1_addr", RW'(port_c_write_addr), RW'(1));
        check("t2_c1_data", port_c_in, RW'(32'h1));
        check("t2_d1_we", RW'(port_d_we), RW'(1));
        check("t2_d1_addr", RW'(port_d_write_addr), RW'(2));
        check("t2_d1_data", port_d_in, RW'(32'h2));
        @(negedge clk);
        check("t2_c2_we", RW'(port_c_we), RW'(1));
        check("t2_c2_addr", RW'(port_c_write_addr), RW'(3));
        check("t2_d2_we", RW'(port_d_we), RW'(0));
        check("t2_d2_addr_hold", RW'(port_d_write_addr), RW'(2));
        // rr_ptr is back at 0, so source 1 is visited before source 2.
        src_valid = 3'b110;
        src_addr  = {AW'(9), AW'(8), AW'(0)};
        src_data  = {RW'(32'h92), RW'(32'h81), RW'(0)};
        @(negedge clk);
        src_valid = '0;
        check("t2_idle_we", RW'(port_c_we), RW'(0));
        @(negedge clk);
        check("t2_rr_c_addr", RW'(port_c_write_addr), RW'(8));
        check("t2_rr_c_data", port_c_in, RW'(32'h81));
        check("t2_rr_d_addr", RW'(port_d_write_addr), RW'(9));
        check("t2_rr_d_we", RW'(port_d_we), RW'(1));

        // Same address from sources 0 and 2.
        do_reset();
        src_valid = 3'b101;
        src_addr  = {AW'(7), AW'(0), AW'(7)};
        src_data  = {RW'(32'h22), RW'(0), RW'(32'h11)};
        @(negedge clk);
        src_valid = '0;
        check("t3_pend", RW'(pend_mask), RW'(16'h0080));
        @(negedge clk);
        check("t3_c1_we", RW'(port_c_we), RW'(1));
        check("t3_c1_addr", RW'(port_c_write_addr), RW'(7));
        check("t3_c1_data", port_c_in, RW'(32'h11));
        check("t3_d1_we", RW'(port_d_we), RW'(0));
        check("t3_pend_mid", RW'(pend_mask), RW'(16'h0080));
        @(negedge clk);
        check("t3_c2_we", RW'(port_c_we), RW'(1));
        check("t3_c2_addr", RW'(port_c_write_addr), RW'(7));
        check("t3_c2_data", port_c_in, RW'(32'h22));
        check("t3_d2_we", RW'(port_d_we), RW'(0));
        @(negedge clk);
        check("t3_idle", RW'(port_c_we), RW'(0));

        // Source 0 stalled by same-address traffic from 1 and 2: its FIFO must fill.
        do_reset();
        addr_mode = 1;
        c = 0;
        while (c < 60 && acc_cnt[0] < 8) begin
            sb_cycle(3'b111);
            @(negedge clk);
            c++;
        end
        check("t4_src0_accepts", RW'(acc_cnt[0]), RW'(8));
        check("t4_ready0_dropped", RW'(saw_full0), RW'(1));
        sb_cycle(3'b000);
        drain("t4");

        // Saturating random traffic.
        do_reset();
        addr_mode = 0;
        for (int n = 0; n < 300; n++) begin
            sb_cycle(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111);
            @(negedge clk);
        end
        sb_cycle(3'b000);
        drain("t5");
        check("t5_some_traffic", RW'(wr_cnt[0] > 50 && wr_cnt[1] > 50 && wr_cnt[2] > 50), RW'(1));

        // Reset in mid-operation discards everything.
        do_reset();
        src_valid = 3'b111;
        src_addr  = {AW'(4), AW'(4), AW'(4)};
        src_data  = {RW'(32'h3), RW'(32'h2), RW'(32'h1)};
        @(negedge clk);
        @(negedge clk);
        src_valid = '0;
        check("t6_busy_we", RW'(port_c_we), RW'(1));
        check("t6_busy_pend", RW'(pend_mask), RW'(16'h0010));
        rst_n = 1'b0;
        #1;
        check("t6_rst_c_we", RW'(port_c_we), RW'(0));
        check("t6_rst_d_we", RW'(port_d_we), RW'(0));
        check("t6_rst_pend", RW'(pend_mask), RW'(0));
        check("t6_rst_ready", RW'(src_ready), RW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (port_c_we || port_d_we || pend_mask != '0) stale++;
        end
        check("t6_no_stale", RW'(stale), RW'(0));
        check("t6_ready", RW'(src_ready), RW'(3'b111));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter REG_CNT, default 4, registers per thread.
REQ-002 Parameter SUPERSCALAR_WIDTH, default 4, thread count.
REQ-003 Parameter REG_WIDTH, default 288, write-data width (4x4 matrix of 18-bit elements).
REQ-004 Parameter DEPTH, default 4, per-source queue depth; SHALL be a power of 2 and at least 2.
REQ-005 Derived constants SHALL be fixed at NREG = REG_CNT*SUPERSCALAR_WIDTH and ADDR_W = clog2(NREG); the source count SHALL be fixed at 3.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 src_valid  in  3  per-source write request (0 = matmul, 1 = ALU, 2 = load).
REQ-009 src_ready  out  3  per-source accept.
REQ-010 src_addr  in  3*ADDR_W  per-source destination register; source i occupies slice i.
REQ-011 src_data  in  3*REG_WIDTH  per-source write data; source i occupies slice i.
REQ-012 port_c_we, port_d_we  out  1 each  register-file write enables.
REQ-013 port_c_write_addr, port_d_write_addr  out  ADDR_W each  write addresses.
REQ-014 port_c_in, port_d_in  out  REG_WIDTH each  write data.
REQ-015 pend_mask  out  NREG  bit a is 1 while a write to register a is queued or presented.

Function
REQ-016 Each source SHALL own a FIFO of DEPTH {addr, data} entries.
REQ-017 src_ready[i] SHALL equal (count_i < DEPTH), registered-state only, with no combinational path from src_valid; a full FIFO SHALL not accept even when its head pops in the same cycle.
REQ-018 A transfer SHALL occur on an edge where src_valid[i] and src_ready[i] are both 1; src_addr and src_data SHALL be sampled on that edge.
REQ-019 Arbitration SHALL be combinational on FIFO heads each cycle, visiting sources in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-020 The first non-empty source SHALL be granted port C.
REQ-021 The next non-empty source whose head address differs from the port-C address SHALL be granted port D; a same-address head SHALL be skipped that cycle and stay queued.
REQ-022 Each granted FIFO SHALL pop exactly one entry; at most one pop per source per cycle.
REQ-023 port_*_we, port_*_write_addr and port_*_in SHALL be registered from the grant; when there is no grant, we SHALL be 0 and addr/data SHALL hold their previous values.
REQ-024 Latency SHALL be: accepted on edge k into an empty FIFO with no competing heads -> we=1 in the cycle after edge k+1.
REQ-025 port_c_write_addr and port_d_write_addr SHALL never be equal while both we are 1.
REQ-026 rr_ptr SHALL update to (index of last granted source in visit order + 1) mod 3 and hold when nothing is granted.
REQ-027 Per-source order SHALL be preserved; order between sources SHALL be defined only by grant sequence.
REQ-028 pend_mask SHALL be the OR over all FIFO entries plus the output registers whose we=1, updated from registered state only.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH with no overflow or underflow.

Reset
REQ-030 While rst_n=0: FIFOs empty, rr_ptr=0, src_ready=0, both we=0, addresses 0, data 0, pend_mask 0.
REQ-031 src_ready SHALL be 3'b111 from the first cycle after rst_n rises.
REQ-032 Reset asserted mid-operation SHALL discard all queued and presented writes, with no write issued afterwards.

Verification
REQ-033 Scenario: source 1 only, addr 5, data 0xA after reset -> port_c_we=1, addr 5, data 0xA one cycle after accept; port_d_we=0; pend_mask bit 5 set for 2 cycles.
REQ-034 Scenario: sources 0, 1, 2 accepted together, addrs 1, 2, 3, rr_ptr=0 -> cycle 1: C=1, D=2; cycle 2: C=3; rr_ptr sequence 2, 0.
REQ-035 Scenario: sources 0 and 2 both write addr 7 with data 0x11 and 0x22 -> C=7/0x11, then next cycle C=7/0x22; port D never writes addr 7.
REQ-036 Scenario: source 0 driven valid for 6 cycles with DEPTH=4 and the output stalled by continuous higher-rr traffic -> src_ready[0] drops after 4 accepts, no entry lost, all 6 written in order.
REQ-037 Scenario: rst_n pulsed low with 3 entries queued -> immediately we=0 and pend_mask=0; after release no stale write appears.
REQ-038 Scenario: saturating random traffic with a scoreboard -> no duplicate C/D address, per-source order kept, each source granted within 2 cycles of being at its FIFO head.
